ans_bcd_converter: RTL and testbench
====================================

ANS_BCD_CONVERTER -- requirements
Module: ans_bcd_converter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named sw_clk and rst.
REQ-002 sw_clk  input  1  system clock (keypad/interface clock domain); all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-low reset, sampled on the sw_clk rising edge.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 ans  input  32  calculator result, two's complement; sampled on the accepting edge.
REQ-006 err  input  1  calculator error flag; sampled with ans.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  single-cycle pulse; fnd_serial is valid and updated in the same cycle.
REQ-009 fnd_serial  output  32  display word for segment_driver: [31] negative, [30] overflow, [29] error, [28:24] zero, [23:0] six BCD digits (digit 5 at [23:20], digit 0 at [3:0]); digit code 4'hF means blank.

Function
REQ-010 The FSM SHALL have states IDLE, ABS, SHIFT, FORMAT; all other encodings SHALL go to IDLE.
REQ-011 IDLE with start=1 -> ABS: latch ans, err, and neg=ans[31]; busy=1 from the next cycle.
REQ-012 ABS -> SHIFT, one cycle: magnitude = neg ? (~ans+1) : ans, as 32-bit unsigned (0x80000000 -> 2147483648); clear the 40-bit BCD accumulator and the 6-bit iteration counter.
REQ-013 SHIFT SHALL perform exactly 32 double-dabble iterations, one per cycle: add 3 to each of the 10 BCD nibbles that is >=5, then shift {bcd, mag} left by 1; after iteration 32 -> FORMAT.
REQ-014 FORMAT, one cycle: build fnd_serial, pulse done=1, clear busy, -> IDLE.
REQ-015 Latency: when start is accepted on edge N, fnd_serial updates and done=1 after edge N+34, with busy=1 from after edge N through edge N+33.
REQ-016 Latency SHALL be fixed at 35 cycles, independent of ans and err.
REQ-017 Overflow SHALL be flagged when magnitude > 999999, i.e. any of BCD nibbles 9..6 is non-zero.
REQ-018 Format priority:
  - err: 32'h20FF_FFFF.
  - else overflow: {neg,1'b1,6'b0,24'hFF_FFFF}.
  - else normal: {neg,7'b0,digits}.
REQ-019 Leading-zero blanking: for digits 5..1, replace each zero digit with 4'hF while all higher digits are zero/blank; digit 0 SHALL never be blanked.
REQ-020 Magnitude 0 SHALL produce neg=0, digits 24'hFF_FFF0.
REQ-021 start while busy SHALL be ignored: it is not queued and the latched operands are unchanged.
REQ-022 start in the done cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-023 ans and err changes after acceptance SHALL not affect the running conversion.
REQ-024 fnd_serial SHALL hold its value between done pulses.

Reset
REQ-025 rst=0 SHALL force, at the next edge, regardless of state:
  - state IDLE;
  - busy=0, done=0;
  - fnd_serial=32'h00FF_FFF0;
  - counter and accumulator cleared.
REQ-026 Reset mid-conversion SHALL abort with no done pulse and no partial result visible.
REQ-027 If rst=0 and start=1 on the same edge, reset SHALL win and start is not accepted.

Verification
REQ-028 Reset, then ans=0, start -> done exactly 35 edges later, fnd_serial=32'h00FF_FFF0; ans=12345 -> 32'h00F1_2345.
REQ-029 ans=32'hFFFF_FFF9 (-7) -> 32'h80FF_FFF7; ans=-999999 -> 32'h8099_9999.
REQ-030 ans=999999 -> 32'h0099_9999; ans=1000000 -> 32'h40FF_FFFF; ans=32'h8000_0000 -> 32'hC0FF_FFFF.
REQ-031 err=1 with ans=5 -> 32'h20FF_FFFF, with the same 35-cycle latency.
REQ-032 Start ans=42, then pulse start with ans=7 at cycle 10 -> a single done with 32'h00FF_FF42; start in the done cycle is accepted.
REQ-033 Assert rst=0 at cycle 20 of a conversion -> busy=0 next cycle, no done, fnd_serial=32'h00FF_FFF0; the next start converts normally.

Source files
------------

// File: rtl/ans_bcd_converter_if.sv
// Handshake and result bus between the calculator core and the BCD display converter.
interface ans_bcd_converter_if;
  logic        start;
  logic [31:0] ans;
  logic        err;
  logic        busy;
  logic        done;
  logic [31:0] fnd_serial;

  modport master (
    output start, ans, err,
    input  busy, done, fnd_serial
  );

  modport slave (
    input  start, ans, err,
    output busy, done, fnd_serial
  );
endinterface

// File: rtl/ans_bcd_converter.sv
// Converts a signed 32-bit calculator result into a six-digit BCD display word
// using a fixed-latency sequential double-dabble.
module ans_bcd_converter (
  input  logic               sw_clk,
  input  logic               rst,
  ans_bcd_converter_if.slave cvt
);

  typedef enum logic [1:0] {StIdle, StAbs, StShift, StFormat} state_e;

  localparam logic [31:0] FndReset = 32'h00FF_FFF0;
  localparam logic [31:0] FndError = 32'h20FF_FFFF;

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [39:0] bcd_q, bcd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] fnd_q, fnd_d;

  logic [39:0] bcd_adj;
  logic [23:0] digits;
  logic        blank;
  logic        overflow;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Blank leading zeros from digit 5 down; digit 0 always shows.
  always_comb begin
    digits = bcd_q[23:0];
    blank  = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      if (blank && (digits[4*i +: 4] == 4'd0)) begin
        digits[4*i +: 4] = 4'hF;
      end else begin
        blank = 1'b0;
      end
    end
  end

  assign overflow = |bcd_q[39:24];

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fnd_d   = fnd_q;
    case (state_q)
      StIdle: begin
        if (cvt.start) begin
          mag_d   = cvt.ans;
          err_d   = cvt.err;
          neg_d   = cvt.ans[31];
          busy_d  = 1'b1;
          state_d = StAbs;
        end
      end
      StAbs: begin
        mag_d   = neg_q ? (~mag_q + 32'd1) : mag_q;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        {bcd_d, mag_d} = {bcd_adj[38:0], mag_q, 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = StFormat;
        end
      end
      StFormat: begin
        if (err_q) begin
          fnd_d = FndError;
        end else if (overflow) begin
          fnd_d = {neg_q, 1'b1, 6'b0, 24'hFF_FFFF};
        end else begin
          fnd_d = {neg_q, 7'b0, digits};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sw_clk) begin
    if (!rst) begin
      state_q <= StIdle;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fnd_q   <= FndReset;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fnd_q   <= fnd_d;
    end
  end

  assign cvt.busy       = busy_q;
  assign cvt.done       = done_q;
  assign cvt.fnd_serial = fnd_q;

endmodule

// File: tb/tb_ans_bcd_converter.sv
// Directed, table-driven bench for ans_bcd_converter.
module tb_ans_bcd_converter;

  logic sw_clk;
  logic rst;
  int   total;
  int   bad;

  ans_bcd_converter_if cvt ();

  ans_bcd_converter dut (
    .sw_clk (sw_clk),
    .rst    (rst),
    .cvt    (cvt)
  );

  initial sw_clk = 1'b0;
  always #5 sw_clk = ~sw_clk;

  typedef struct {
    logic [31:0] ans;
    logic        err;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sw_clk);
    #1;
  endtask

  // Drives start for one edge, scrambles operands afterwards, and waits for done.
  task automatic run_conv(input logic [31:0] a, input logic e, input logic [31:0] exp,
                          input string nm);
    int n;
    cvt.ans   = a;
    cvt.err   = e;
    cvt.start = 1'b1;
    tick();
    cvt.start = 1'b0;
    cvt.ans   = ~a;
    cvt.err   = ~e;
    check({nm, " busy after accept"}, {31'b0, cvt.busy}, 32'd1);
    n = 0;
    while (!cvt.done && n < 100) begin
      tick();
      n++;
    end
    check({nm, " latency"}, n, 32'd34);
    check({nm, " fnd_serial"}, cvt.fnd_serial, exp);
    check({nm, " busy at done"}, {31'b0, cvt.busy}, 32'd0);
  endtask

  initial begin
    int          dones;
    int          lat;
    logic [31:0] cap;

    total = 0;
    bad   = 0;
    vecs[0]  = '{32'd0,        1'b0, 32'h00FF_FFF0};
    vecs[1]  = '{32'd12345,    1'b0, 32'h00F1_2345};
    vecs[2]  = '{32'hFFFF_FFF9, 1'b0, 32'h80FF_FFF7};
    vecs[3]  = '{32'hFFF0_BDC1, 1'b0, 32'h8099_9999};
    vecs[4]  = '{32'd999999,   1'b0, 32'h0099_9999};
    vecs[5]  = '{32'd1000000,  1'b0, 32'h40FF_FFFF};
    vecs[6]  = '{32'h8000_0000, 1'b0, 32'hC0FF_FFFF};
    vecs[7]  = '{32'd5,        1'b1, 32'h20FF_FFFF};
    vecs[8]  = '{32'hFFFF_FFF9, 1'b1, 32'h20FF_FFFF};
    vecs[9]  = '{32'd100,      1'b0, 32'h00FF_F100};
    vecs[10] = '{32'd7,        1'b0, 32'h00FF_FFF7};
    vecs[11] = '{32'd1000,     1'b0, 32'h00FF_1000};
    vecs[12] = '{32'hFFF0_BDBF, 1'b0, 32'hC0FF_FFFF};
    vecs[13] = '{32'd100005,   1'b0, 32'h0010_0005};

    rst       = 1'b0;
    cvt.start = 1'b0;
    cvt.ans   = '0;
    cvt.err   = 1'b0;
    repeat (3) tick();
    check("reset busy", {31'b0, cvt.busy}, 32'd0);
    check("reset done", {31'b0, cvt.done}, 32'd0);
    check("reset fnd_serial", cvt.fnd_serial, 32'h00FF_FFF0);

    // Reset and start on the same edge: reset wins, nothing queued.
    cvt.start = 1'b1;
    cvt.ans   = 32'd5;
    tick();
    check("rst+start busy", {31'b0, cvt.busy}, 32'd0);
    rst       = 1'b1;
    cvt.start = 1'b0;
    tick();
    check("rst+start not queued", {31'b0, cvt.busy}, 32'd0);

    // Back-to-back: each start after the first lands in the previous done cycle.
    for (int i = 0; i < 14; i++) begin
      run_conv(vecs[i].ans, vecs[i].err, vecs[i].exp, $sformatf("vec%0d", i));
    end

    repeat (5) tick();
    check("hold done low", {31'b0, cvt.done}, 32'd0);
    check("hold fnd_serial", cvt.fnd_serial, vecs[13].exp);

    // Start while busy is ignored.
    cvt.ans   = 32'd42;
    cvt.err   = 1'b0;
    cvt.start = 1'b1;
    tick();
    dones = 0;
    lat   = -1;
    cap   = '0;
    for (int c = 1; c <= 80; c++) begin
      cvt.start = (c == 10);
      if (c == 10) cvt.ans = 32'd7;
      tick();
      if (cvt.done) begin
        dones++;
        if (lat < 0) begin
          lat = c;
          cap = cvt.fnd_serial;
        end
      end
    end
    check("busy-start done count", dones, 32'd1);
    check("busy-start latency", lat, 32'd34);
    check("busy-start fnd_serial", cap, 32'h00FF_FF42);

    // Reset mid-conversion aborts without a result.
    cvt.ans   = 32'd12345;
    cvt.start = 1'b1;
    tick();
    cvt.start = 1'b0;
    repeat (19) tick();
    check("pre-abort busy", {31'b0, cvt.busy}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort busy", {31'b0, cvt.busy}, 32'd0);
    check("abort done", {31'b0, cvt.done}, 32'd0);
    check("abort fnd_serial", cvt.fnd_serial, 32'h00FF_FFF0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (cvt.done) dones++;
    end
    check("abort no done", dones, 32'd0);
    check("abort fnd held", cvt.fnd_serial, 32'h00FF_FFF0);
    run_conv(32'd999, 1'b0, 32'h00FF_F999, "post-abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
